// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl : EX-stage hazard/sequencing controller (stall, flush,
//                    forwarding selects, multi-cycle start/done/timeout).
// Optional feature macro: HAZ_PERF_CNT_EN (stall/flush performance counters).
// Revision: 1.0
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MC_MAX_LAT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_is_mc,
  input  logic             ex_redirect,
  input  logic             mem_valid,
  input  logic             wb_valid,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_is_load,
  input  logic             mc_done,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mc_start,
  output logic             mc_abort,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  localparam int                TMO_W    = $clog2(MC_MAX_LAT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_MAX_LAT - 1);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             mc_timeout_q, mc_timeout_d;

  logic w_stall_if, w_stall_id, w_stall_ex, w_bubble_ex;
  logic w_flush_if, w_flush_id, w_mc_start, w_mc_abort;
  logic w_load_use;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       m_valid,
                                         input logic       m_is_load,
                                         input logic [4:0] m_rd,
                                         input logic       w_valid,
                                         input logic [4:0] w_rd);
    if (rs == 5'd0)                               return 2'b00;
    else if (m_valid && !m_is_load && m_rd == rs) return 2'b01;
    else if (w_valid && w_rd == rs)               return 2'b10;
    else                                          return 2'b00;
  endfunction

  assign w_load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) && id_valid &&
                      ((id_use_rs1 && id_rs1 == ex_rd) ||
                       (id_use_rs2 && id_rs2 == ex_rd));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      tmo_cnt_q    <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    mc_timeout_d = mc_timeout_q;
    w_stall_if   = 1'b0;
    w_stall_id   = 1'b0;
    w_stall_ex   = 1'b0;
    w_bubble_ex  = 1'b0;
    w_flush_if   = 1'b0;
    w_flush_id   = 1'b0;
    w_mc_start   = 1'b0;
    w_mc_abort   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A taken redirect squashes ID, so any hazard it carries is moot.
        if (ex_valid && ex_redirect) begin
          w_flush_if = 1'b1;
          w_flush_id = 1'b1;
        end else if (ex_valid && ex_is_mc) begin
          w_mc_start = 1'b1;
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
          tmo_cnt_d  = '0;
          state_d    = ST_MC_WAIT;
        end else if (w_load_use) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_bubble_ex = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        // Done takes precedence over a timeout landing in the same cycle.
        if (mc_done) begin
          tmo_cnt_d = '0;
          state_d   = ST_RUN;
        end else if (tmo_cnt_q == TMO_LAST) begin
          w_mc_abort   = 1'b1;
          mc_timeout_d = 1'b1;
          tmo_cnt_d    = '0;
          state_d      = ST_RUN;
        end else begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
          tmo_cnt_d  = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Every output is forced low while reset is asserted.
  assign stall_if   = reset_n & w_stall_if;
  assign stall_id   = reset_n & w_stall_id;
  assign stall_ex   = reset_n & w_stall_ex;
  assign bubble_ex  = reset_n & w_bubble_ex;
  assign flush_if   = reset_n & w_flush_if;
  assign flush_id   = reset_n & w_flush_id;
  assign mc_start   = reset_n & w_mc_start;
  assign mc_abort   = reset_n & w_mc_abort;
  assign mc_timeout = reset_n & mc_timeout_q;
  assign fwd_a_sel  = {2{reset_n}} &
                      fwd_sel(id_rs1, mem_valid, mem_is_load, mem_rd, wb_valid, wb_rd);
  assign fwd_b_sel  = {2{reset_n}} &
                      fwd_sel(id_rs2, mem_valid, mem_is_load, mem_rd, wb_valid, wb_rd);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_W-1:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {{(CNT_W-1){1'b0}}, stall_if};
    perf_flush_d = perf_flush_q + {{(CNT_W-1){1'b0}}, flush_id};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
`default_nettype wire
